// File: rtl/m_seq_checker.sv
// PRBS7 receive checker: self-synchronises a local predictor to the recovered
// bit stream, then counts checked bits and bit errors for BER measurement.
module m_seq_checker #(
  parameter int LFSR_W = 7,
  parameter int TAP_A  = 7,
  parameter int TAP_B  = 6,
  parameter int SYNC_N = 16,
  parameter int WIN    = 64,
  parameter int ERR_TH = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk_2m,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             sync,
  output logic             err_pulse,
  output logic [15:0]      err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int SEED_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(SYNC_N + 1);
  localparam int WIN_W   = $clog2(WIN);
  localparam int WERR_W  = $clog2(ERR_TH + 1);

  typedef enum logic [1:0] {IDLE, SEED, VERIFY, CHECK} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   hist_q;
  logic [SEED_W-1:0]   seed_cnt_q;
  logic [MATCH_W-1:0]  match_cnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [WERR_W-1:0]   win_err_q;

  logic                pred, mismatch, step;
  logic                seed_last, verify_last, win_last, th_hit;
  logic [LFSR_W-1:0]   hist_seed;
  logic [WERR_W-1:0]   win_err_inc;

  assign pred        = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
  assign mismatch    = bit_in ^ pred;
  // Losing lock suppresses all per-bit processing, including err_pulse.
  assign step        = bit_valid & locked;
  assign hist_seed   = {hist_q[LFSR_W-2:0], bit_in};
  assign seed_last   = (seed_cnt_q == SEED_W'(LFSR_W - 1));
  assign verify_last = (match_cnt_q == MATCH_W'(SYNC_N - 1));
  assign win_last    = (win_cnt_q == WIN_W'(WIN - 1));
  assign win_err_inc = win_err_q + WERR_W'(mismatch);
  assign th_hit      = (win_err_inc >= WERR_W'(ERR_TH));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_2m or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d takes a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!locked) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = SEED;
        SEED:   if (bit_valid && seed_last && hist_seed != '0) state_d = VERIFY;
        VERIFY: if (bit_valid) begin
                  if (mismatch)         state_d = SEED;
                  else if (verify_last) state_d = CHECK;
                end
        CHECK:  if (bit_valid && mismatch && th_hit) state_d = SEED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sync = (state_q == CHECK);
  end

  always_ff @(posedge clk_2m or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
      bit_cnt     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (state_q == IDLE) seed_cnt_q <= '0;
      if (step) begin
        case (state_q)
          SEED: begin
            hist_q      <= hist_seed;
            seed_cnt_q  <= seed_last ? '0 : seed_cnt_q + SEED_W'(1);
            match_cnt_q <= '0;
          end
          VERIFY: begin
            hist_q      <= hist_seed;
            match_cnt_q <= mismatch ? '0 : match_cnt_q + MATCH_W'(1);
            win_cnt_q   <= '0;
            win_err_q   <= '0;
          end
          CHECK: begin
            // Free-running predictor: received errors never enter hist.
            hist_q    <= {hist_q[LFSR_W-2:0], pred};
            win_cnt_q <= win_last ? '0 : win_cnt_q + WIN_W'(1);
            win_err_q <= win_last ? '0 : win_err_inc;
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
      if (clr_cnt) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: vector table for idle/seed behaviour plus
// PRBS7 stream sequences for sync, error, resync, lock-loss and reset cases.
`timescale 1ns/1ps
module tb_m_seq_checker;

  logic        clk_2m, rst_n, locked, bit_valid, bit_in, clr_cnt;
  logic        sync, err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  m_seq_checker dut (
    .clk_2m(clk_2m), .rst_n(rst_n), .locked(locked), .bit_valid(bit_valid),
    .bit_in(bit_in), .clr_cnt(clr_cnt), .sync(sync), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  initial clk_2m = 1'b0;
  always #250 clk_2m = ~clk_2m;

  typedef struct {
    logic        locked, bit_valid, bit_in, clr_cnt;
    logic        exp_sync, exp_pulse;
    logic [15:0] exp_err;
    logic [31:0] exp_bits;
  } vec_t;

  vec_t        vecs[15];
  int          n_cmp = 0, n_err = 0;
  int          idle_gap = 1;
  int          pulse_total, bit_idx;
  logic [6:0]  gen_state;
  bit          drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; strobe is taken on the next posedge, outputs sampled
  // at the following negedge.
  task automatic send_bit(input logic b, input logic clr);
    bit_valid = 1'b1; bit_in = b; clr_cnt = clr;
    @(negedge clk_2m);
    pulse_total += int'(err_pulse);
    bit_valid = 1'b0; clr_cnt = 1'b0;
    repeat (idle_gap) @(negedge clk_2m);
  endtask

  task automatic next_prbs(output logic b);
    b = gen_state[6] ^ gen_state[5];
    gen_state = {gen_state[5:0], b};
  endtask

  task automatic send_prbs(input logic inv, input logic clr);
    logic b;
    next_prbs(b);
    bit_idx++;
    send_bit(b ^ inv, clr);
    if (bit_idx > 23 && !sync) drop = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_2m);
    rst_n = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0; bit_in = 1'b0; locked = 1'b1;
    @(negedge clk_2m);
    rst_n = 1'b1;
    @(negedge clk_2m);
    gen_state = 7'h7F; pulse_total = 0; bit_idx = 0; drop = 1'b0;
  endtask

  initial begin
    #(500.0 * 40000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic b;

    // {locked, valid, bit, clr} -> all outputs stay zero: IDLE, then SEED
    // restarting forever on an all-zero stream, with clears in between.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    for (int i = 3; i < 14; i++)
      vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0};

    rst_n = 1'b0; locked = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk_2m);
    check("reset_sync", 64'(sync), 64'd0);
    check("reset_pulse", 64'(err_pulse), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_bit_cnt", 64'(bit_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_2m);

    for (int i = 0; i < 15; i++) begin
      locked = vecs[i].locked; bit_valid = vecs[i].bit_valid;
      bit_in = vecs[i].bit_in; clr_cnt = vecs[i].clr_cnt;
      @(negedge clk_2m);
      check($sformatf("vec%0d", i), 64'({sync, err_pulse, err_cnt, bit_cnt}),
            64'({vecs[i].exp_sync, vecs[i].exp_pulse, vecs[i].exp_err, vecs[i].exp_bits}));
    end
    bit_valid = 1'b0; clr_cnt = 1'b0;

    // Clean stream: sync after bit 23, then 1000 checked bits back to back.
    do_reset();
    n = 0;
    for (int i = 1; i <= 23; i++) begin
      send_prbs(1'b0, 1'b0);
      if (sync && n == 0) n = i;
    end
    check("clean_sync_bit", 64'(n), 64'd23);
    idle_gap = 0;
    for (int i = 0; i < 1000; i++) send_prbs(1'b0, 1'b0);
    idle_gap = 1;
    check("clean_bit_cnt", 64'(bit_cnt), 64'd1000);
    check("clean_err_cnt", 64'(err_cnt), 64'd0);
    check("clean_pulses", 64'(pulse_total), 64'd0);
    check("clean_no_drop", 64'(drop), 64'd0);
    send_prbs(1'b0, 1'b1);
    check("clr_with_bit", 64'(bit_cnt), 64'd0);
    send_prbs(1'b0, 1'b0);
    check("count_after_clr", 64'(bit_cnt), 64'd1);

    // Single inverted bit 500: one error, no propagation, sync held.
    do_reset();
    idle_gap = 0;
    for (int i = 1; i <= 600; i++) send_prbs(i == 500, 1'b0);
    idle_gap = 1;
    check("single_pulses", 64'(pulse_total), 64'd1);
    check("single_err_cnt", 64'(err_cnt), 64'd1);
    check("single_sync", 64'(sync), 64'd1);
    check("single_no_drop", 64'(drop), 64'd0);
    check("single_bit_cnt", 64'(bit_cnt), 64'd577);

    // Eight errors in one window: sync falls on the 8th, reacquires in 23.
    do_reset();
    for (int i = 0; i < 23; i++) send_prbs(1'b0, 1'b0);
    for (int k = 0; k <= 24; k++) begin
      send_prbs(k >= 10 && k % 2 == 0, 1'b0);
      if (k == 22) check("burst_sync_after_7", 64'(sync), 64'd1);
    end
    check("burst_sync_after_8", 64'(sync), 64'd0);
    check("burst_err_cnt", 64'(err_cnt), 64'd8);
    check("burst_pulses", 64'(pulse_total), 64'd8);
    check("burst_bit_cnt", 64'(bit_cnt), 64'd25);
    n = 0;
    while (n < 100) begin
      send_prbs(1'b0, 1'b0);
      n++;
      if (sync) break;
    end
    check("reacquire_bits", 64'(n), 64'd23);
    check("reacquire_bit_cnt", 64'(bit_cnt), 64'd25);
    for (int i = 0; i < 5; i++) send_prbs(1'b0, 1'b0);
    check("post_reacq_bit_cnt", 64'(bit_cnt), 64'd30);

    // Asynchronous reset mid-CHECK, asserted between clock edges.
    #100;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({sync, err_pulse, err_cnt, bit_cnt}), 64'd0);

    // Four errors in each of two windows: no resync.
    do_reset();
    for (int i = 0; i < 23; i++) send_prbs(1'b0, 1'b0);
    for (int k = 0; k < 200; k++)
      send_prbs(k == 10 || k == 20 || k == 30 || k == 40 ||
                k == 70 || k == 80 || k == 90 || k == 100, 1'b0);
    check("spread_no_drop", 64'(drop), 64'd0);
    check("spread_err_cnt", 64'(err_cnt), 64'd8);
    check("spread_pulses", 64'(pulse_total), 64'd8);
    check("spread_bit_cnt", 64'(bit_cnt), 64'd200);

    // Lock loss with a wrong bit strobed: sync drops, no pulse, counts kept.
    next_prbs(b);
    locked = 1'b0; bit_valid = 1'b1; bit_in = ~b;
    @(negedge clk_2m);
    bit_valid = 1'b0;
    check("unlock_sync", 64'(sync), 64'd0);
    check("unlock_pulse", 64'(err_pulse), 64'd0);
    check("unlock_err_cnt", 64'(err_cnt), 64'd8);
    check("unlock_bit_cnt", 64'(bit_cnt), 64'd200);
    clr_cnt = 1'b1;
    @(negedge clk_2m);
    clr_cnt = 1'b0;
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_bit_cnt", 64'(bit_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/m_seq_checker.md
Name: m_seq_checker

Overview:
- Receive-side counterpart of the M-sequence generator and DPLL clock recovery path.
- Samples the recovered data stream on strobes derived from the recovered clock and self-synchronises a local PRBS7 predictor to it.
- Once synchronised, compares every received bit against the prediction and reports sync status, bit errors and bit count (BER measurement).
- Sits after the DPLL in the 2 MHz domain, next to the existing top.

Parameters:
- LFSR_W, 7, sequence order; received sequence obeys b[n] = b[n-TAP_A] XOR b[n-TAP_B]
- TAP_A, 7, first feedback tap (x^7)
- TAP_B, 6, second feedback tap (x^6)
- SYNC_N, 16, consecutive correct bits in VERIFY needed to declare sync
- WIN, 64, loss-of-sync observation window in bits
- ERR_TH, 8, errors within one window that force resync
- CNT_W, 32, width of bit_cnt; err_cnt is 16 bits

Ports:
- clk_2m  in  1  system clock, 2 MHz
- rst_n  in  1  asynchronous active-low reset
- locked  in  1  DPLL lock indication; low forces IDLE
- bit_valid  in  1  one-cycle strobe, one per recovered bit period
- bit_in  in  1  recovered data bit, valid when bit_valid=1
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- sync  out  1  predictor synchronised (state CHECK)
- err_pulse  out  1  one-cycle pulse per detected bit error
- err_cnt  out  16  saturating error count
- bit_cnt  out  CNT_W  saturating count of bits checked in CHECK

Behaviour:
- Reset: state=IDLE, hist=0, all counters 0, sync=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- hist is an LFSR_W-bit history register; pred = hist[TAP_A-1] XOR hist[TAP_B-1], where hist[0] holds the newest bit.
- All state, counter and output updates occur on clk_2m edges with bit_valid=1, except clr_cnt and locked handling.
- Outputs are registered: one cycle after the bit_valid cycle.
- States:
  - IDLE: if locked=1, go to SEED with seed count=0.
  - SEED: shift bit_in into hist. After LFSR_W bits, go to VERIFY. If the resulting hist is all zeros, restart SEED instead (all-zero is illegal for an M-sequence).
  - VERIFY: compare bit_in against pred and shift bit_in into hist. Any mismatch returns to SEED with counts cleared. SYNC_N consecutive matches go to CHECK.
  - CHECK: shift pred (not bit_in) into hist so the predictor free-runs. Each bit increments bit_cnt. A mismatch increments err_cnt and asserts err_pulse. On window error count >= ERR_TH, go to SEED.
- sync=1 exactly while in CHECK.
- Window: the bit counter runs 0..WIN-1 with an error counter inside it. At wrap, the window error counter clears. The threshold test uses the count including the current bit, so resync can happen mid-window.
- Saturation: err_cnt holds at 16'hFFFF; bit_cnt holds at all-ones.
- clr_cnt=1 zeroes err_cnt and bit_cnt that cycle. If it coincides with a counted bit, the clear wins and the bit is not counted. It does not affect state or sync.
- locked=0 in any state: next cycle state=IDLE and sync=0. Counters are retained, and err_pulse is not generated for that bit.
- bit_valid during two consecutive cycles is legal; each strobe is processed.

Test Plan:
- Clean PRBS7 stream (x^7+x^6+1, seed 7'h7F) at one strobe per 200 cycles with locked=1 -> sync rises after bit 7+16=23; after 1000 further bits: bit_cnt=1000, err_cnt=0.
- Same stream with bit 500 (after sync) inverted -> exactly one err_pulse, err_cnt=1, sync stays 1. Free-running prediction means no error propagation.
- After sync, invert 8 bits within one 64-bit window -> sync falls on the 8th error; reacquires 23 bits after errors stop. err_cnt=8.
- Same 8 errors spread as 4 per window across two windows -> no resync, err_cnt=8.
- Constant zero input -> never leaves SEED, sync=0. Then drop locked mid-CHECK -> sync=0 next cycle, counters retained. Assert clr_cnt -> both counters 0.
- Assert rst_n low mid-CHECK -> all outputs 0 immediately, without waiting for a clock edge.
